// File: rtl/ram_clearable.sv
// Single-port RAM with a combinational read and a self-timed clear sweep.
// Reset restarts the sweep. It does not touch the array itself.
module ram_clearable #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e               state_q;
  logic [ADDR_BITS-1:0] ptr_q;
  logic                 done_q;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [WIDTH-1:0]     mem_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StSweep;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clear) begin
            state_q <= StSweep;
            ptr_q   <= '0;
          end
        end
        StSweep: begin
          // The pointer wraps to zero on the last word, so it is left at 0 for the next sweep.
          ptr_q <= ptr_q + 1'b1;
          if (&ptr_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A sweep owns the write port. Host loads are dropped while it runs.
  always_comb begin
    mem_we    = load;
    mem_waddr = addr;
    mem_wdata = in;
    if (state_q == StSweep) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end
  end

  // Gate with reset so that no edge seen while reset is held writes the array.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out  = mem[addr];
  assign busy = (state_q == StSweep);
  assign done = done_q;

endmodule

// File: tb/tb_ram_clearable.sv
// Directed bench for ram_clearable: a default 16x64 instance and a small 8x8 instance.
module tb_ram_clearable;

  logic        clock = 1'b0;
  logic        reset;

  logic [15:0] in;
  logic [5:0]  addr;
  logic        load, clear;
  logic [15:0] out;
  logic        busy, done;

  logic [7:0]  in8;
  logic [2:0]  addr8;
  logic        load8, clear8;
  logic [7:0]  out8;
  logic        busy8, done8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ram_clearable dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .addr  (addr),
    .load  (load),
    .clear (clear),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  ram_clearable #(
    .WIDTH     (8),
    .ADDR_BITS (3)
  ) dut8 (
    .clock (clock),
    .reset (reset),
    .in    (in8),
    .addr  (addr8),
    .load  (load8),
    .clear (clear8),
    .out   (out8),
    .busy  (busy8),
    .done  (done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sweep_64(input string tag);
    for (int i = 0; i < 64; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, " busy end"}, 32'(busy), 32'd0);
    chk({tag, " done pulse"}, 32'(done), 32'd1);
  endtask

  task automatic all_zero(input string tag);
    for (int a = 0; a < 64; a++) begin
      addr = a[5:0];
      #1;
      chk({tag, " zero"}, 32'(out), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    in = '0; addr = '0; load = 1'b0; clear = 1'b0;
    in8 = '0; addr8 = '0; load8 = 1'b0; clear8 = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    tick();
    tick();
    chk("reset held busy", 32'(busy), 32'd1);
    reset = 1'b0;

    // Power-up sweep: 64 busy cycles, then done for exactly one cycle.
    sweep_64("init");
    tick();
    chk("init done low", 32'(done), 32'd0);
    chk("init busy low", 32'(busy), 32'd0);
    all_zero("init");

    // Write followed by a zero-latency read.
    tick();
    addr = 6'd5; in = 16'hBEEF; load = 1'b1;
    tick();
    load = 1'b0;
    #1;
    chk("rd 5", 32'(out), 32'h0000BEEF);
    addr = 6'd6;
    #1;
    chk("rd 6", 32'(out), 32'h0);

    // Fill every word with addr+1.
    tick();
    for (int a = 0; a < 64; a++) begin
      addr = a[5:0]; in = 16'(a + 1); load = 1'b1;
      tick();
    end
    load = 1'b0;
    addr = 6'd0;  #1; chk("fill 0", 32'(out), 32'd1);
    addr = 6'd63; #1; chk("fill 63", 32'(out), 32'd64);

    // Clear with a load in the same cycle: the load still lands.
    tick();
    clear = 1'b1; load = 1'b1; addr = 6'd10; in = 16'hAAAA;
    tick();
    clear = 1'b0;
    chk("clr+load", 32'(out), 32'h0000AAAA);
    addr = 6'd40; #1; chk("unswept 40", 32'(out), 32'd41);
    // Loads during the sweep must be dropped; mem[63] keeps old data until swept.
    addr = 6'd63; in = 16'h1234; load = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      chk("swp busy", 32'(busy), 32'd1);
      chk("swp out63", 32'(out), 32'd64);
      tick();
    end
    chk("swp busy end", 32'(busy), 32'd0);
    chk("swp done", 32'(done), 32'd1);
    chk("swp out63 zero", 32'(out), 32'd0);
    load = 1'b0;
    tick();
    chk("swp done low", 32'(done), 32'd0);
    all_zero("swp");

    // A clear during a sweep does not restart it.
    tick();
    clear = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      clear = (i == 10);
      chk("reclr busy", 32'(busy), 32'd1);
      tick();
    end
    clear = 1'b0;
    chk("reclr busy end", 32'(busy), 32'd0);
    chk("reclr done", 32'(done), 32'd1);
    tick();
    chk("reclr done low", 32'(done), 32'd0);
    chk("reclr idle", 32'(busy), 32'd0);

    // Reset in mid-sweep restarts a full 64-cycle sweep.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy), 32'd1);
    chk("mid rst done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    sweep_64("rst");
    tick();
    chk("rst done low", 32'(done), 32'd0);

    // Small instance: 8-cycle sweep.
    addr8 = 3'd7; in8 = 8'hA5; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    chk("s8 rd 7", 32'(out8), 32'hA5);
    clear8 = 1'b1;
    tick();
    clear8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s8 busy", 32'(busy8), 32'd1);
      chk("s8 done", 32'(done8), 32'd0);
      tick();
    end
    chk("s8 busy end", 32'(busy8), 32'd0);
    chk("s8 done pulse", 32'(done8), 32'd1);
    chk("s8 rd 7 zero", 32'(out8), 32'h0);
    tick();
    chk("s8 done low", 32'(done8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
